// File: rtl/alu_pkg.sv
// Shared ALU control definitions: sequencer state encoding used by the
// serial arithmetic blocks and the ALU control sequencer.
package alu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_subtractor.sv
// 1-bit full subtractor cell: d = a - b - bin, with borrow-out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/seq_sub_xbit.sv
// Bit-serial ripple-borrow subtractor: diff = inA - inB - bin over WIDTH
// cycles through one full_subtractor cell, with start/busy/done handshake.
module seq_sub_xbit
  import alu_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   a_sr, b_sr;
  logic               br;
  logic [CNT_W-1:0]   cnt;
  logic               a_msb, b_msb;
  logic               fs_d, fs_b;
  logic               accept, last_bit;
  logic [WIDTH-1:0]   diff_shift;

  full_subtractor u_fs (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (br),
    .d    (fs_d),
    .bout (fs_b)
  );

  assign accept     = start && (state == ST_IDLE || state == ST_DONE);
  assign last_bit   = (state == ST_RUN) && (cnt == CNT_W'(WIDTH - 1));
  assign diff_shift = {fs_d, diff[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      ST_IDLE: if (start) state_nxt = ST_RUN;
      ST_RUN: begin
        busy = 1'b1;
        if (cnt == CNT_W'(WIDTH - 1)) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = start ? ST_RUN : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Operand capture and one bit of subtraction per RUN cycle; flags are
  // registered on the edge that shifts in the final result bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr  <= '0;
      b_sr  <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
      ovf   <= 1'b0;
      zero  <= 1'b0;
    end else if (accept) begin
      a_sr  <= inA;
      b_sr  <= inB;
      br    <= bin;
      cnt   <= '0;
      a_msb <= inA[WIDTH-1];
      b_msb <= inB[WIDTH-1];
    end else if (state == ST_RUN) begin
      a_sr <= a_sr >> 1;
      b_sr <= b_sr >> 1;
      br   <= fs_b;
      cnt  <= cnt + CNT_W'(1);
      diff <= diff_shift;
      if (last_bit) begin
        bout <= fs_b;
        ovf  <= (a_msb ^ b_msb) & (fs_d ^ a_msb);
        zero <= (diff_shift == '0);
      end
    end
  end

endmodule

// File: tb/tb_seq_sub_xbit.sv
// Self-checking bench for seq_sub_xbit: directed table, handshake corner
// cases, reset abort, back-to-back operation and randomized ops vs a model.
module tb_seq_sub_xbit;

  logic       clk = 1'b0;
  logic       rst;
  logic       start4, bin4, busy4, done4, bout4, ovf4, zero4;
  logic [3:0] a4, b4, diff4;
  logic       start8, bin8, busy8, done8, bout8, ovf8, zero8;
  logic [7:0] a8, b8, diff8;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seq_sub_xbit #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .inA(a4), .inB(b4), .bin(bin4),
    .busy(busy4), .done(done4), .diff(diff4), .bout(bout4), .ovf(ovf4), .zero(zero4)
  );

  seq_sub_xbit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .inA(a8), .inB(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8), .ovf(ovf8), .zero(zero8)
  );

  typedef struct {
    logic [3:0] a, b;
    logic       bi;
    logic [3:0] d;
    logic       bo, ov, z;
  } vec_t;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: unsigned modular difference, borrow = negative unsigned
  // result, overflow = signed result outside the w-bit two's-complement range.
  function automatic void model(input int w, input longint a, input longint b, input int bi,
                                output longint d, output bit bo, output bit ov, output bit z);
    longint m, raw, sa, sb, sr;
    m   = longint'(1) << w;
    raw = a - b - bi;
    d   = ((raw % m) + m) % m;
    bo  = (raw < 0);
    sa  = (a >= m / 2) ? a - m : a;
    sb  = (b >= m / 2) ? b - m : b;
    sr  = sa - sb - bi;
    ov  = (sr < -(m / 2)) || (sr > (m / 2) - 1);
    z   = (d == 0);
  endfunction

  // Start one W=4 op, scramble inputs after accept, stop in the done cycle.
  task automatic do_op4(input logic [3:0] a, input logic [3:0] b, input logic bi, input string nm);
    int lat;
    a4 = a; b4 = b; bin4 = bi; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    a4 = 4'($urandom); b4 = 4'($urandom); bin4 = 1'($urandom);
    lat = 0;
    while (!done4 && lat < 12) begin
      check({nm, "_busy"}, busy4, 1);
      tick();
      lat++;
    end
    check({nm, "_lat"}, lat, 4);
    check({nm, "_busy_in_done"}, busy4, 0);
  endtask

  task automatic do_op8(input logic [7:0] a, input logic [7:0] b, input logic bi, input string nm);
    int lat;
    longint ed;
    bit ebo, eov, ez;
    a8 = a; b8 = b; bin8 = bi; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    lat = 0;
    while (!done8 && lat < 20) begin
      tick();
      lat++;
    end
    model(8, longint'(a), longint'(b), int'(bi), ed, ebo, eov, ez);
    check({nm, "_lat"}, lat, 8);
    check({nm, "_diff"}, diff8, ed);
    check({nm, "_bout"}, bout8, ebo);
    check({nm, "_ovf"}, ovf8, eov);
    check({nm, "_zero"}, zero8, ez);
    tick();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, busy4=%0d done4=%0d", busy4, done4);
    $fatal(1, "simulation time limit");
  end

  initial begin
    vec_t   tbl[5];
    longint ed;
    bit     ebo, eov, ez;
    int     lat, pulses;
    logic [3:0] held;

    tbl[0] = '{a:4'd5, b:4'd3,  bi:1'b0, d:4'd2,  bo:1'b0, ov:1'b0, z:1'b0};
    tbl[1] = '{a:4'd3, b:4'd5,  bi:1'b0, d:4'd14, bo:1'b1, ov:1'b0, z:1'b0};
    tbl[2] = '{a:4'd0, b:4'd0,  bi:1'b1, d:4'd15, bo:1'b1, ov:1'b0, z:1'b0};
    tbl[3] = '{a:4'd7, b:4'd15, bi:1'b0, d:4'd8,  bo:1'b1, ov:1'b1, z:1'b0};
    tbl[4] = '{a:4'd4, b:4'd4,  bi:1'b0, d:4'd0,  bo:1'b0, ov:1'b0, z:1'b1};

    rst = 1'b1; start4 = 0; a4 = 0; b4 = 0; bin4 = 0;
    start8 = 0; a8 = 0; b8 = 0; bin8 = 0;
    tick(); tick();
    check("rst_busy", busy4, 0);
    check("rst_done", done4, 0);
    check("rst_diff", diff4, 0);
    check("rst_flags", {bout4, ovf4, zero4}, 0);
    check("rst_busy8", {busy8, done8}, 0);
    rst = 1'b0;
    tick();

    // Directed table
    for (int i = 0; i < 5; i++) begin
      do_op4(tbl[i].a, tbl[i].b, tbl[i].bi, $sformatf("tbl%0d", i));
      check($sformatf("tbl%0d_diff", i), diff4, tbl[i].d);
      check($sformatf("tbl%0d_bout", i), bout4, tbl[i].bo);
      check($sformatf("tbl%0d_ovf", i), ovf4, tbl[i].ov);
      check($sformatf("tbl%0d_zero", i), zero4, tbl[i].z);
      held = diff4;
      tick();
      check($sformatf("tbl%0d_done_pulse", i), {busy4, done4}, 0);
      check($sformatf("tbl%0d_hold", i), diff4, held);
    end

    // Start pulses while busy are ignored; start in the done cycle is taken
    a4 = 4'd5; b4 = 4'd3; bin4 = 0; start4 = 1;
    tick();
    start4 = 0;
    tick();
    a4 = 4'd1; b4 = 4'd1; start4 = 1;
    tick(); tick();
    start4 = 0;
    lat = 3; pulses = 0;
    while (!done4 && lat < 12) begin tick(); lat++; end
    check("ign_lat", lat, 4);
    check("ign_diff", diff4, 2);
    a4 = 4'd9; b4 = 4'd2; bin4 = 0; start4 = 1;
    tick();
    start4 = 0;
    check("redo_busy", busy4, 1);
    lat = 0;
    while (!done4 && lat < 12) begin tick(); lat++; end
    check("redo_lat", lat, 4);
    check("redo_diff", diff4, 7);
    tick();

    // Asynchronous reset mid-operation
    do_op4(4'd3, 4'd5, 1'b0, "pre_rst");
    tick();
    a4 = 4'd6; b4 = 4'd1; bin4 = 0; start4 = 1;
    tick();
    start4 = 0;
    tick();
    rst = 1'b1;
    #1;
    check("arst_busy", busy4, 0);
    check("arst_done", done4, 0);
    check("arst_diff", diff4, 0);
    check("arst_flags", {bout4, ovf4, zero4}, 0);
    #2 rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done4 || busy4) pulses++;
    end
    check("arst_no_done", pulses, 0);
    do_op4(4'd6, 4'd1, 1'b0, "post_rst");
    check("post_rst_diff", diff4, 5);
    tick();

    // start held high: back-to-back ops every WIDTH+1 cycles
    a4 = 4'd10; b4 = 4'd3; bin4 = 0; start4 = 1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      check($sformatf("b2b_done_c%0d", i), done4, (i % 5 == 0));
      check($sformatf("b2b_excl_c%0d", i), busy4 & done4, 0);
      if (done4) begin
        check($sformatf("b2b_diff_c%0d", i), diff4, 7);
        check($sformatf("b2b_bout_c%0d", i), bout4, 0);
      end
    end
    start4 = 0;
    tick();

    // Randomized W=4 ops against the model
    for (int i = 0; i < 30; i++) begin
      logic [3:0] ra, rb;
      logic rbi;
      ra = 4'($urandom); rb = 4'($urandom); rbi = 1'($urandom);
      model(4, longint'(ra), longint'(rb), int'(rbi), ed, ebo, eov, ez);
      do_op4(ra, rb, rbi, $sformatf("rnd%0d", i));
      check($sformatf("rnd%0d_diff", i), diff4, ed);
      check($sformatf("rnd%0d_bout", i), bout4, ebo);
      check($sformatf("rnd%0d_ovf", i), ovf4, eov);
      check($sformatf("rnd%0d_zero", i), zero4, ez);
      tick();
    end

    // WIDTH=8 instance
    do_op8(8'd200, 8'd201, 1'b0, "w8_200_201");
    do_op8(8'd127, 8'd128, 1'b0, "w8_ovf");
    do_op8(8'd128, 8'd1, 1'b0, "w8_negovf");
    for (int i = 0; i < 10; i++)
      do_op8(8'($urandom), 8'($urandom), 1'($urandom), $sformatf("w8rnd%0d", i));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
